// File: rtl/ph_pwm_seq_ctrl.sv
// ph_pwm_seq_ctrl: soft-start / soft-stop sequencer for a 3-phase PWM generator.
//
// Ramps the duty command from 0 up to a latched target in DUTY_STEP increments,
// one increment every STEP_DIV clocks. It holds the target while running, then
// ramps back down to 0 on a stop request. An external fault forces an immediate
// shutdown into a lockout state. The lockout is left only through an explicit
// clear request (with the fault gone) or through reset. Every output is a flop.
//
// Parameters:
//   STEP_DIV    clocks per duty step (1..65535)
//   DUTY_STEP   duty increment/decrement per step (1..255)
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset
//   START        one-cycle soft-start request (accepted in IDLE only)
//   STOP         one-cycle soft-stop request
//   FAULT        level fault input, highest priority
//   FAULT_CLR    one-cycle request to leave lockout
//   DUTY_TARGET  run duty, sampled only when START is accepted
//   PWM_EN       enable for the PWM generator
//   DUTY         current duty command
//   AT_SPEED     high while running at the target duty
//   BUSY         high while ramping up, running or ramping down
//   FAULTED      high while in lockout
module ph_pwm_seq_ctrl #(
  parameter int unsigned STEP_DIV  = 25000,
  parameter int unsigned DUTY_STEP = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       FAULT,
  input  logic       FAULT_CLR,
  input  logic [7:0] DUTY_TARGET,
  output logic       PWM_EN,
  output logic [7:0] DUTY,
  output logic       AT_SPEED,
  output logic       BUSY,
  output logic       FAULTED
);

  localparam logic [15:0] PRESC_MAX = 16'(STEP_DIV - 1);
  localparam logic [8:0]  STEP9     = 9'(DUTY_STEP);

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StRun,
    StRampDown,
    StLockout
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  tgt_q, tgt_d;
  logic [15:0] presc_q, presc_d;
  logic        pwm_en_q, pwm_en_d;
  logic        at_speed_q, busy_q, faulted_q;

  logic        step;
  logic [8:0]  up_sum;
  logic [7:0]  up_val;
  logic [7:0]  down_val;

  // Prescaler terminal count marks the one cycle in which a duty step is taken.
  assign step = (presc_q == PRESC_MAX);

  // Ramp-up sum is computed 9 bits wide so a step past 255 saturates at the
  // target instead of wrapping.
  assign up_sum = {1'b0, duty_q} + STEP9;
  always_comb begin
    up_val = up_sum[7:0];
    if (up_sum >= {1'b0, tgt_q}) begin
      up_val = tgt_q;
    end
  end

  // Ramp-down clamps at zero.
  always_comb begin
    down_val = duty_q - STEP9[7:0];
    if ({1'b0, duty_q} <= STEP9) begin
      down_val = 8'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    tgt_d    = tgt_q;
    presc_d  = presc_q;
    pwm_en_d = pwm_en_q;

    if (FAULT) begin
      state_d  = StLockout;
      duty_d   = 8'd0;
      pwm_en_d = 1'b0;
      presc_d  = 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          duty_d   = 8'd0;
          presc_d  = 16'd0;
          // A ramp-down enters IDLE with PWM_EN still high; it drops here,
          // one cycle after DUTY reached 0.
          pwm_en_d = 1'b0;
          if (START && !STOP) begin
            tgt_d    = DUTY_TARGET;
            state_d  = StRampUp;
            pwm_en_d = 1'b1;
          end
        end

        StRampUp: begin
          pwm_en_d = 1'b1;
          if (STOP) begin
            presc_d = 16'd0;
            if (duty_q == 8'd0) begin
              // Nothing to ramp down from: shut off at once.
              state_d  = StIdle;
              pwm_en_d = 1'b0;
            end else begin
              state_d = StRampDown;
            end
          end else if (tgt_q == 8'd0) begin
            state_d = StRun;
            presc_d = 16'd0;
          end else if (step) begin
            presc_d = 16'd0;
            duty_d  = up_val;
            if (up_val == tgt_q) begin
              state_d = StRun;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end

        StRun: begin
          pwm_en_d = 1'b1;
          duty_d   = tgt_q;
          presc_d  = 16'd0;
          if (STOP) begin
            state_d = StRampDown;
          end
        end

        StRampDown: begin
          pwm_en_d = 1'b1;
          if (step) begin
            presc_d = 16'd0;
            duty_d  = down_val;
            if (down_val == 8'd0) begin
              state_d = StIdle;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end

        StLockout: begin
          duty_d   = 8'd0;
          pwm_en_d = 1'b0;
          presc_d  = 16'd0;
          // FAULT is known low on this path.
          if (FAULT_CLR) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d  = StIdle;
          duty_d   = 8'd0;
          pwm_en_d = 1'b0;
          presc_d  = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      duty_q     <= 8'd0;
      tgt_q      <= 8'd0;
      presc_q    <= 16'd0;
      pwm_en_q   <= 1'b0;
      at_speed_q <= 1'b0;
      busy_q     <= 1'b0;
      faulted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      tgt_q      <= tgt_d;
      presc_q    <= presc_d;
      pwm_en_q   <= pwm_en_d;
      // Status flags are decoded from the next state so they change on the
      // same edge as the state itself.
      at_speed_q <= (state_d == StRun);
      busy_q     <= (state_d == StRampUp) || (state_d == StRun) || (state_d == StRampDown);
      faulted_q  <= (state_d == StLockout);
    end
  end

  assign PWM_EN   = pwm_en_q;
  assign DUTY     = duty_q;
  assign AT_SPEED = at_speed_q;
  assign BUSY     = busy_q;
  assign FAULTED  = faulted_q;

endmodule

// File: doc/ph_pwm_seq_ctrl.md
PH_PWM_SEQ_CTRL -- requirements
Module: ph_pwm_seq_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 25000, clocks per duty step (1 ms at 25 MHz), legal range 1..65535.
REQ-002 SHALL have parameter DUTY_STEP, default 1, duty increment/decrement per step, legal range 1..255.
REQ-003 SHALL have port CLK  input  1  single system clock (25 MHz); all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  one-cycle request to begin soft-start.
REQ-006 SHALL have port STOP  input  1  one-cycle request to begin soft-stop.
REQ-007 SHALL have port FAULT  input  1  level, external fault; highest priority.
REQ-008 SHALL have port FAULT_CLR  input  1  one-cycle request to leave fault lockout.
REQ-009 SHALL have port DUTY_TARGET  input  8  run duty; sampled only on an accepted START.
REQ-010 SHALL have port PWM_EN  output  1  drives ENABLE of the 3-phase PWM generator.
REQ-011 SHALL have port DUTY  output  8  current duty command to the PWM generator.
REQ-012 SHALL have port AT_SPEED  output  1  high in RUN only.
REQ-013 SHALL have port BUSY  output  1  high in RAMP_UP, RUN, RAMP_DOWN.
REQ-014 SHALL have port FAULTED  output  1  high in LOCKOUT only.

Function
REQ-015 SHALL implement states IDLE, RAMP_UP, RUN, RAMP_DOWN, LOCKOUT; all outputs registered.
REQ-016 SHALL apply per-cycle priority: FAULT > STOP > START > ramp step.
REQ-017 SHALL, when FAULT=1 in any state, enter LOCKOUT next cycle with PWM_EN=0, DUTY=0, prescaler cleared.
REQ-018 SHALL leave LOCKOUT to IDLE only when FAULT_CLR=1 and FAULT=0 in the same cycle; otherwise stay.
REQ-019 SHALL, in IDLE on START=1 with STOP=0, latch DUTY_TARGET into tgt, enter RAMP_UP, PWM_EN=1 next cycle, DUTY=0, prescaler cleared.
REQ-020 SHALL ignore START in every state except IDLE; START and STOP together in IDLE leave state IDLE.
REQ-021 SHALL, if latched tgt=0, go RAMP_UP -> RUN on the first cycle in RAMP_UP with DUTY=0.
REQ-022 SHALL run a prescaler in RAMP_UP/RAMP_DOWN counting 0..STEP_DIV-1; terminal count produces one step then wraps to 0.
REQ-023 SHALL, on a RAMP_UP step, set DUTY=min(DUTY+DUTY_STEP, tgt) using 9-bit arithmetic (no 8-bit wrap); when result equals tgt, enter RUN same edge.
REQ-024 SHALL, in RUN, hold DUTY=tgt and PWM_EN=1; STOP enters RAMP_DOWN with prescaler cleared.
REQ-025 SHALL, on STOP in RAMP_UP, enter RAMP_DOWN from current DUTY, prescaler cleared.
REQ-026 SHALL, on a RAMP_DOWN step, set DUTY=max(DUTY-DUTY_STEP, 0) with no underflow; when result is 0, enter IDLE same edge; PWM_EN=0 from the following cycle.
REQ-027 SHALL, on STOP in RAMP_UP with DUTY=0, go straight to IDLE next cycle with PWM_EN=0.
REQ-028 SHALL ignore STOP in IDLE and LOCKOUT, and FAULT_CLR outside LOCKOUT.
REQ-029 SHALL ignore DUTY_TARGET changes after START is accepted.

Reset
REQ-030 SHALL, with RESET=1 at a rising edge, force state IDLE, PWM_EN=0, DUTY=0, AT_SPEED=0, BUSY=0, FAULTED=0, tgt=0, prescaler=0.
REQ-031 SHALL let RESET override FAULT and all requests, including mid-ramp and in LOCKOUT (reset exits LOCKOUT).
REQ-032 SHALL produce outputs from the first edge after RESET deasserts only if an input requests a transition.

Verification (STEP_DIV=4, DUTY_STEP=16 unless stated)
REQ-033 SHALL cover soft-start: START, DUTY_TARGET=64 -> PWM_EN=1 next cycle, DUTY 16/32/48/64 every 4 clocks, AT_SPEED=1 with DUTY=64 after 16 clocks.
REQ-034 SHALL cover saturation: DUTY_TARGET=250, DUTY_STEP=16 -> DUTY ...,240,250 (no wrap), RUN; then STOP -> 234,...,10,0, IDLE, PWM_EN=0 one cycle after DUTY=0.
REQ-035 SHALL cover fault: FAULT=1 mid RAMP_UP at DUTY=32 -> next cycle PWM_EN=0, DUTY=0, FAULTED=1; START ignored; FAULT_CLR while FAULT=1 ignored; FAULT=0+FAULT_CLR -> IDLE.
REQ-036 SHALL cover abort: STOP at DUTY=48 during RAMP_UP -> RAMP_DOWN 32,16,0 then IDLE; START+STOP same cycle in IDLE -> stays IDLE.
REQ-037 SHALL cover reset mid-operation: RESET=1 in RUN at DUTY=64 -> next edge all outputs 0, state IDLE.
REQ-038 SHALL cover tgt=0 and DUTY_TARGET change in RUN: START with 0 -> RUN, DUTY=0, PWM_EN=1; changing DUTY_TARGET to 99 in RUN -> DUTY unchanged.
